// File: rtl/tx_fc_credit_gate_if.sv
// Bundles the flow-control update path and the arbiter request/grant path of
// tx_fc_credit_gate.
//   master : driven by the arbiter / DLL side (updates, requests); sees grants and status
//   slave  : the credit gate itself
// Signals:
//   fc_upd_valid/type/hdr/data : FC limit update (type 0=P 1=NP 2=CPL 3=ignored)
//   req_valid/cmd/ptlp         : per-port TLP request, 3-bit command and payload length in DW
//   req_grant                  : same-cycle grant per port
//   fc_ready                   : {CPL,NP,P} initialised
//   req_err                    : registered pulse on a reserved command
//   fc_timeout                 : sticky {CPL,NP,P} update watchdog flags
interface tx_fc_credit_gate_if #(
  parameter int unsigned FC_HDR_WIDTH  = 12,
  parameter int unsigned FC_DATA_WIDTH = 16,
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned PTLP_WIDTH    = 10
);
  logic                          fc_upd_valid;
  logic [1:0]                    fc_upd_type;
  logic [FC_HDR_WIDTH-1:0]       fc_upd_hdr;
  logic [FC_DATA_WIDTH-1:0]      fc_upd_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [3*NUM_REQ-1:0]          req_cmd;
  logic [PTLP_WIDTH*NUM_REQ-1:0] req_ptlp;
  logic [NUM_REQ-1:0]            req_grant;
  logic [2:0]                    fc_ready;
  logic                          req_err;
  logic [2:0]                    fc_timeout;

  modport master (
    output fc_upd_valid, fc_upd_type, fc_upd_hdr, fc_upd_data, req_valid, req_cmd, req_ptlp,
    input  req_grant, fc_ready, req_err, fc_timeout
  );

  modport slave (
    input  fc_upd_valid, fc_upd_type, fc_upd_hdr, fc_upd_data, req_valid, req_cmd, req_ptlp,
    output req_grant, fc_ready, req_err, fc_timeout
  );
endinterface

// File: rtl/tx_fc_credit_gate.sv
// Transmit flow-control credit gate. Keeps credit limit (CL) and credits consumed (CC) for
// Posted, Non-Posted and Completion header/data credits, grants up to NUM_REQ TLP requests per
// cycle in strict port order using modular credit arithmetic, and commits consumed credits on
// the next edge.
// Ports:
//   clk  : clock
//   arst : asynchronous reset, active-high
//   bus  : tx_fc_credit_gate_if.slave (FC updates, requests, grants, status)
// Optional feature: define TX_FC_WATCHDOG_EN to build one update watchdog per type
// (TIMEOUT_CYC cycles, sticky fc_timeout); otherwise fc_timeout is tied to 0.
module tx_fc_credit_gate #(
  parameter int unsigned FC_HDR_WIDTH  = 12,
  parameter int unsigned FC_DATA_WIDTH = 16,
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned PTLP_WIDTH    = 10
`ifdef TX_FC_WATCHDOG_EN
  , parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
  input logic                  clk,
  input logic                  arst,
  tx_fc_credit_gate_if.slave   bus
);

  typedef enum logic {st_uninit, st_active} fc_state_e;

  localparam logic [2:0] cmd_none = 3'd0;
  localparam logic [2:0] cmd_rsvd = 3'd7;
  // Largest modular distance still counted as "enough credit left".
  localparam logic [FC_HDR_WIDTH-1:0]  hdr_half  = FC_HDR_WIDTH'(1) << (FC_HDR_WIDTH - 1);
  localparam logic [FC_DATA_WIDTH-1:0] data_half = FC_DATA_WIDTH'(1) << (FC_DATA_WIDTH - 1);

  fc_state_e                state_q   [3];
  fc_state_e                state_d   [3];
  logic [FC_HDR_WIDTH-1:0]  cl_hdr_q  [3];
  logic [FC_HDR_WIDTH-1:0]  cl_hdr_d  [3];
  logic [FC_DATA_WIDTH-1:0] cl_data_q [3];
  logic [FC_DATA_WIDTH-1:0] cl_data_d [3];
  logic [FC_HDR_WIDTH-1:0]  cc_hdr_q  [3];
  logic [FC_HDR_WIDTH-1:0]  acc_hdr   [3];
  logic [FC_DATA_WIDTH-1:0] cc_data_q [3];
  logic [FC_DATA_WIDTH-1:0] acc_data  [3];
  logic [2:0]               hdr_inf_q, hdr_inf_d, data_inf_q, data_inf_d;
  logic [2:0]               upd_hit;
  logic                     err_q, err_d;
  logic [NUM_REQ-1:0]       grant;

  // Per-type init FSM and CL load. Infinite (zero-at-init) fields never change afterwards.
  always_comb begin
    for (int t = 0; t < 3; t++) begin
      upd_hit[t]    = bus.fc_upd_valid && (bus.fc_upd_type == 2'(t));
      state_d[t]    = state_q[t];
      cl_hdr_d[t]   = cl_hdr_q[t];
      cl_data_d[t]  = cl_data_q[t];
      hdr_inf_d[t]  = hdr_inf_q[t];
      data_inf_d[t] = data_inf_q[t];
      if (upd_hit[t]) begin
        case (state_q[t])
          st_uninit: begin
            state_d[t]    = st_active;
            cl_hdr_d[t]   = bus.fc_upd_hdr;
            cl_data_d[t]  = bus.fc_upd_data;
            hdr_inf_d[t]  = (bus.fc_upd_hdr == '0);
            data_inf_d[t] = (bus.fc_upd_data == '0);
          end
          st_active: begin
            if (!hdr_inf_q[t])  cl_hdr_d[t]  = bus.fc_upd_hdr;
            if (!data_inf_q[t]) cl_data_d[t] = bus.fc_upd_data;
          end
          default: ;
        endcase
      end
    end
  end

  // In-order grant evaluation. acc_* carries CC plus the needs of earlier granted ports and
  // becomes the next CC.
  always_comb begin
    logic [2:0]               cmd;
    logic [1:0]               ty;
    logic [PTLP_WIDTH:0]      ptlp_sum;
    logic [FC_DATA_WIDTH-1:0] need_data;
    logic [FC_HDR_WIDTH-1:0]  hdr_left;
    logic [FC_DATA_WIDTH-1:0] data_left;
    logic                     fits;
    logic                     blocked;
    grant   = '0;
    err_d   = 1'b0;
    blocked = 1'b0;
    for (int t = 0; t < 3; t++) begin
      acc_hdr[t]  = cc_hdr_q[t];
      acc_data[t] = cc_data_q[t];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd = bus.req_cmd[3*i +: 3];
      case (cmd)
        3'd3, 3'd4: ty = 2'd1;
        3'd5, 3'd6: ty = 2'd2;
        default:    ty = 2'd0;
      endcase
      // ceil(ptlp/4); even command codes are the _D variants
      ptlp_sum  = {1'b0, bus.req_ptlp[PTLP_WIDTH*i +: PTLP_WIDTH]} + (PTLP_WIDTH+1)'(3);
      need_data = cmd[0] ? '0 : FC_DATA_WIDTH'(ptlp_sum >> 2);
      hdr_left  = cl_hdr_q[ty] - (acc_hdr[ty] + FC_HDR_WIDTH'(1));
      data_left = cl_data_q[ty] - (acc_data[ty] + need_data);
      fits      = (state_q[ty] == st_active) &&
                  (hdr_inf_q[ty] || (hdr_left <= hdr_half)) &&
                  (data_inf_q[ty] || (data_left <= data_half));
      if (bus.req_valid[i] && (cmd != cmd_none)) begin
        if (cmd == cmd_rsvd) begin
          err_d   = 1'b1;
          blocked = 1'b1;
        end else if (!blocked && fits) begin
          grant[i]     = 1'b1;
          acc_hdr[ty]  = acc_hdr[ty] + FC_HDR_WIDTH'(1);
          acc_data[ty] = acc_data[ty] + need_data;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int t = 0; t < 3; t++) begin
        state_q[t]   <= st_uninit;
        cl_hdr_q[t]  <= '0;
        cl_data_q[t] <= '0;
        cc_hdr_q[t]  <= '0;
        cc_data_q[t] <= '0;
      end
      hdr_inf_q  <= '0;
      data_inf_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int t = 0; t < 3; t++) begin
        state_q[t]   <= state_d[t];
        cl_hdr_q[t]  <= cl_hdr_d[t];
        cl_data_q[t] <= cl_data_d[t];
        cc_hdr_q[t]  <= acc_hdr[t];
        cc_data_q[t] <= acc_data[t];
      end
      hdr_inf_q  <= hdr_inf_d;
      data_inf_q <= data_inf_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_grant = grant;
  assign bus.req_err   = err_q;
  assign bus.fc_ready  = {state_q[2] == st_active, state_q[1] == st_active,
                          state_q[0] == st_active};

`ifdef TX_FC_WATCHDOG_EN
  localparam int unsigned        wd_width = $clog2(TIMEOUT_CYC + 1);
  localparam logic [wd_width-1:0] wd_limit = wd_width'(TIMEOUT_CYC);

  logic [wd_width-1:0] wd_cnt_q [3];
  logic [wd_width-1:0] wd_cnt_d [3];
  logic [2:0]          timeout_q, timeout_d;

  always_comb begin
    for (int t = 0; t < 3; t++) begin
      wd_cnt_d[t]  = wd_cnt_q[t];
      timeout_d[t] = timeout_q[t];
      if (state_q[t] == st_active) begin
        if (upd_hit[t]) begin
          wd_cnt_d[t] = '0;
        end else if (wd_cnt_q[t] != wd_limit) begin
          wd_cnt_d[t] = wd_cnt_q[t] + wd_width'(1);
        end
        if (wd_cnt_d[t] == wd_limit) timeout_d[t] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int t = 0; t < 3; t++) wd_cnt_q[t] <= '0;
      timeout_q <= '0;
    end else begin
      for (int t = 0; t < 3; t++) wd_cnt_q[t] <= wd_cnt_d[t];
      timeout_q <= timeout_d;
    end
  end

  assign bus.fc_timeout = timeout_q;
`else
  assign bus.fc_timeout = 3'b000;
`endif

endmodule

// File: tb/tb_tx_fc_credit_gate.sv
module tb_tx_fc_credit_gate;
  localparam int unsigned HW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned NR = 2;
  localparam int unsigned PW = 10;
  localparam longint HMOD = longint'(1) << HW;
  localparam longint DMOD = longint'(1) << DW;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  tx_fc_credit_gate_if #(.FC_HDR_WIDTH(HW), .FC_DATA_WIDTH(DW), .NUM_REQ(NR),
                         .PTLP_WIDTH(PW)) bus ();

`ifdef TX_FC_WATCHDOG_EN
  tx_fc_credit_gate #(.FC_HDR_WIDTH(HW), .FC_DATA_WIDTH(DW), .NUM_REQ(NR), .PTLP_WIDTH(PW),
                      .TIMEOUT_CYC(16)) dut (.clk(clk), .arst(arst), .bus(bus));
`else
  tx_fc_credit_gate #(.FC_HDR_WIDTH(HW), .FC_DATA_WIDTH(DW), .NUM_REQ(NR), .PTLP_WIDTH(PW))
    dut (.clk(clk), .arst(arst), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: credit state per type, tracked as plain integers.
  bit     m_act [3];
  bit     m_hinf[3];
  bit     m_dinf[3];
  longint m_clh [3];
  longint m_cld [3];
  longint m_cch [3];
  longint m_ccd [3];
  bit     m_err;
  longint p_cch [3];
  longint p_ccd [3];
  bit     p_err;
  logic [NR-1:0] exp_grant;

  // Current stimulus
  bit     s_uv;
  int     s_ut;
  longint s_uh, s_ud;
  bit     s_v   [NR];
  int     s_cmd [NR];
  int     s_ptlp[NR];

  function automatic bit fits(longint cl, longint used, longint md);
    longint room;
    room = ((cl - used) % md + md) % md;
    return room <= md / 2;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 3; t++) begin
      m_act[t] = 0; m_hinf[t] = 0; m_dinf[t] = 0;
      m_clh[t] = 0; m_cld[t] = 0; m_cch[t] = 0; m_ccd[t] = 0;
    end
    m_err = 0;
  endtask

  task automatic set_idle();
    s_uv = 0; s_ut = 0; s_uh = 0; s_ud = 0;
    for (int i = 0; i < NR; i++) begin
      s_v[i] = 0; s_cmd[i] = 0; s_ptlp[i] = 0;
    end
  endtask

  task automatic set_req(int p, int cmd, int ptlp);
    s_v[p] = 1; s_cmd[p] = cmd; s_ptlp[p] = ptlp;
  endtask

  task automatic set_upd(int t, longint h, longint d);
    s_uv = 1; s_ut = t; s_uh = h; s_ud = d;
  endtask

  // Push stimulus to the DUT and predict this cycle's grants and next-state credits.
  task automatic drive();
    logic [NR-1:0]    v;
    logic [3*NR-1:0]  c;
    logic [PW*NR-1:0] pl;
    longint ah[3];
    longint ad[3];
    bit blocked;
    int t;
    longint dn;
    for (int i = 0; i < NR; i++) begin
      v[i] = s_v[i];
      c[3*i +: 3] = 3'(s_cmd[i]);
      pl[PW*i +: PW] = PW'(s_ptlp[i]);
    end
    bus.req_valid    = v;
    bus.req_cmd      = c;
    bus.req_ptlp     = pl;
    bus.fc_upd_valid = s_uv;
    bus.fc_upd_type  = 2'(s_ut);
    bus.fc_upd_hdr   = HW'(s_uh);
    bus.fc_upd_data  = DW'(s_ud);
    for (int k = 0; k < 3; k++) begin
      ah[k] = m_cch[k]; ad[k] = m_ccd[k];
    end
    exp_grant = '0; p_err = 0; blocked = 0;
    for (int i = 0; i < NR; i++) begin
      if (s_v[i] && s_cmd[i] != 0) begin
        if (s_cmd[i] == 7) begin
          p_err = 1; blocked = 1;
        end else begin
          t  = (s_cmd[i] - 1) / 2;
          dn = (s_cmd[i] % 2 == 0) ? (s_ptlp[i] + 3) / 4 : 0;
          if (!blocked && m_act[t] && (m_hinf[t] || fits(m_clh[t], ah[t] + 1, HMOD)) &&
              (m_dinf[t] || fits(m_cld[t], ad[t] + dn, DMOD))) begin
            exp_grant[i] = 1'b1;
            ah[t] = (ah[t] + 1) % HMOD;
            ad[t] = (ad[t] + dn) % DMOD;
          end else begin
            blocked = 1;
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      p_cch[k] = ah[k]; p_ccd[k] = ad[k];
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (arst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_cch[k] = p_cch[k]; m_ccd[k] = p_ccd[k];
      end
      m_err = p_err;
      if (s_uv && s_ut < 3) begin
        if (!m_act[s_ut]) begin
          m_act[s_ut] = 1;
          m_clh[s_ut] = s_uh; m_hinf[s_ut] = (s_uh == 0);
          m_cld[s_ut] = s_ud; m_dinf[s_ut] = (s_ud == 0);
        end else begin
          if (!m_hinf[s_ut]) m_clh[s_ut] = s_uh;
          if (!m_dinf[s_ut]) m_cld[s_ut] = s_ud;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    model_reset();
    set_idle();
    drive();
    tick();
    arst = 1'b0;
    model_reset();
  endtask

  task automatic init_type(int t, longint h, longint d);
    set_idle(); set_upd(t, h, d); drive(); tick(); set_idle();
  endtask

  task automatic test_reset();
    arst = 1'b1;
    model_reset();
    set_idle();
    set_req(0, 1, 0);
    drive();
    checks++;
    if (bus.req_grant !== 2'b00) begin
      errors++; $display("FAIL reset_grant got %b want 00", bus.req_grant);
    end
    checks++;
    if (bus.fc_ready !== 3'b000 || bus.req_err !== 1'b0 || bus.fc_timeout !== 3'b000) begin
      errors++;
      $display("FAIL reset_status got ready=%b err=%b to=%b want 000/0/000", bus.fc_ready,
               bus.req_err, bus.fc_timeout);
    end
    tick();
    arst = 1'b0;
  endtask

  task automatic test_uninit();
    do_reset();
    set_idle(); set_req(0, 2, 8); drive();
    checks++;
    if (bus.req_grant !== 2'b00) begin
      errors++; $display("FAIL uninit_grant got %b want 00", bus.req_grant);
    end
    tick();
    init_type(0, 1, 2);
    // P_D ptlp=8 needs exactly hdr 1 / data 2: only fits if nothing was consumed earlier
    set_req(0, 2, 8); drive();
    checks++;
    if (bus.req_grant !== 2'b01) begin
      errors++; $display("FAIL uninit_cc got %b want 01", bus.req_grant);
    end
    tick();
  endtask

  task automatic test_init();
    logic [2:0] want [3];
    want[0] = 3'b001; want[1] = 3'b011; want[2] = 3'b111;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      set_idle(); set_upd(t, (t == 1) ? 15 : 30, 1000); drive();
      checks++;
      if (bus.fc_ready !== ((t == 0) ? 3'b000 : want[t-1])) begin
        errors++; $display("FAIL init_ready_pre%0d got %b", t, bus.fc_ready);
      end
      tick();
      checks++;
      if (bus.fc_ready !== want[t]) begin
        errors++; $display("FAIL init_ready%0d got %b want %b", t, bus.fc_ready, want[t]);
      end
    end
  endtask

  task automatic test_in_order();
    do_reset();
    init_type(0, 2, 100);
    set_req(0, 1, 0); set_req(1, 1, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b11) begin
      errors++; $display("FAIL order_pp got %b want 11", bus.req_grant);
    end
    tick();
    set_idle(); set_req(0, 1, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b00) begin
      errors++; $display("FAIL order_exhausted got %b want 00", bus.req_grant);
    end
    tick();
    // Update and request in the same cycle: grant still sees the old limit
    set_idle(); set_upd(0, 3, 100); set_req(0, 1, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b00) begin
      errors++; $display("FAIL simul_upd_old got %b want 00", bus.req_grant);
    end
    tick();
    set_idle(); set_req(0, 1, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b01) begin
      errors++; $display("FAIL simul_upd_new got %b want 01", bus.req_grant);
    end
    tick();
    init_type(1, 15, 4);
    init_type(2, 30, 1000);
    set_req(0, 4, 20); set_req(1, 5, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b00) begin
      errors++; $display("FAIL np_block got %b want 00", bus.req_grant);
    end
    tick();
    set_idle(); set_req(0, 4, 12); set_req(1, 5, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b11) begin
      errors++; $display("FAIL np_fit got %b want 11", bus.req_grant);
    end
    tick();
  endtask

  task automatic test_infinite();
    int bad = 0;
    do_reset();
    init_type(2, 0, 0);
    for (int n = 0; n < 310; n++) begin
      set_idle();
      if (n == 300) set_upd(2, 5, 5);
      set_req(0, 6, 1023); set_req(1, 6, int'($urandom_range(0, 1023)));
      drive();
      checks++;
      if (bus.req_grant !== 2'b11) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL infinite_grant n=%0d got %b want 11", n, bus.req_grant);
      end
      tick();
    end
  endtask

  task automatic test_reserved();
    do_reset();
    init_type(0, 5, 5);
    set_req(0, 7, 0); set_req(1, 1, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b00 || bus.req_err !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_grant got %b err=%b want 00 err=0", bus.req_grant, bus.req_err);
    end
    tick();
    checks++;
    if (bus.req_err !== 1'b1) begin
      errors++; $display("FAIL rsvd_err got %b want 1", bus.req_err);
    end
    set_idle(); drive(); tick();
    checks++;
    if (bus.req_err !== 1'b0) begin
      errors++; $display("FAIL rsvd_err_clear got %b want 0", bus.req_err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    init_type(0, 1, 10);
    set_req(0, 1, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b01) begin
      errors++; $display("FAIL midrst_pre got %b want 01", bus.req_grant);
    end
    arst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.req_grant !== 2'b00 || bus.fc_ready !== 3'b000) begin
      errors++;
      $display("FAIL midrst_async got grant=%b ready=%b want 00/000", bus.req_grant, bus.fc_ready);
    end
    tick();
    arst = 1'b0;
    model_reset();
    init_type(0, 1, 10);
    set_req(0, 1, 0); drive();
    checks++;
    if (bus.req_grant !== 2'b01) begin
      errors++; $display("FAIL midrst_cc got %b want 01", bus.req_grant);
    end
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    int r, t;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      set_idle();
      if ($urandom_range(0, 3) == 0) begin
        t = int'($urandom_range(0, 3));
        if (t < 3) begin
          s_uh = (m_cch[t] + longint'($urandom_range(0, 4))) % HMOD;
          s_ud = (m_ccd[t] + longint'($urandom_range(0, 60))) % DMOD;
          if ($urandom_range(0, 7) == 0) s_uh = longint'($urandom) % HMOD;
          if ($urandom_range(0, 7) == 0) s_ud = longint'($urandom) % DMOD;
        end
        s_uv = 1; s_ut = t;
      end
      for (int i = 0; i < NR; i++) begin
        s_v[i] = ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 20));
        s_cmd[i] = (r == 20) ? 7 : r % 7;
        s_ptlp[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40))
                                                 : int'($urandom_range(0, 1023));
      end
      drive();
      checks++;
      if (bus.req_grant !== exp_grant) begin
        errors++; bad++;
        if (bad < 8) $display("FAIL rand_grant n=%0d got %b want %b", n, bus.req_grant, exp_grant);
      end
      tick();
      checks++;
      if (bus.req_err !== m_err || bus.fc_ready !== {m_act[2], m_act[1], m_act[0]}) begin
        errors++; bad++;
        if (bad < 8)
          $display("FAIL rand_status n=%0d got err=%b ready=%b want err=%b ready=%b", n,
                   bus.req_err, bus.fc_ready, m_err, {m_act[2], m_act[1], m_act[0]});
      end
`ifndef TX_FC_WATCHDOG_EN
      checks++;
      if (bus.fc_timeout !== 3'b000) begin
        errors++; $display("FAIL rand_timeout got %b want 000", bus.fc_timeout);
      end
`endif
    end
  endtask

`ifdef TX_FC_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    init_type(0, 30, 1000);
    for (int n = 0; n < 15; n++) begin
      set_idle(); drive(); tick();
    end
    checks++;
    if (bus.fc_timeout !== 3'b000) begin
      errors++; $display("FAIL wd_early got %b want 000", bus.fc_timeout);
    end
    set_idle(); drive(); tick();
    checks++;
    if (bus.fc_timeout !== 3'b001) begin
      errors++; $display("FAIL wd_fire got %b want 001", bus.fc_timeout);
    end
    init_type(0, 31, 1000);
    for (int n = 0; n < 3; n++) begin
      set_idle(); drive(); tick();
    end
    checks++;
    if (bus.fc_timeout !== 3'b001) begin
      errors++; $display("FAIL wd_sticky got %b want 001", bus.fc_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_uninit();
    test_init();
    test_in_order();
    test_infinite();
    test_reserved();
    test_mid_reset();
    test_random();
`ifdef TX_FC_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
